// File: rtl/pec_snapshot_streamer.sv
// Captures the performance counter array into a snapshot and streams it out over AXI-Stream
// as one header beat followed by NUM_BEATS data beats.
module pec_snapshot_streamer #(
  parameter int unsigned NUM_COUNTERS   = 115,
  parameter int unsigned COUNTER_WIDTH  = 7,
  parameter int unsigned TDATA_WIDTH    = 64,
  parameter int unsigned AUTO_THRESHOLD = 120,
  localparam int unsigned SNAP_W        = NUM_COUNTERS * COUNTER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SNAP_W-1:0]      counters_flat,
  input  logic                   snapshot_req,
  input  logic                   auto_en,
  output logic                   counters_clear,
  output logic                   busy,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  localparam int unsigned NUM_BEATS = (SNAP_W + TDATA_WIDTH - 1) / TDATA_WIDTH;
  localparam int unsigned PAD_W     = NUM_BEATS * TDATA_WIDTH;
  localparam int unsigned BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [BEAT_W-1:0]        LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [COUNTER_WIDTH-1:0] THRESH    = COUNTER_WIDTH'(AUTO_THRESHOLD);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HEADER = 2'd1;
  localparam logic [1:0] ST_DATA   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SNAP_W-1:0] snap_q;
  logic [BEAT_W-1:0] beat_q;
  logic [15:0]       seq_q, drop_q, hdr_drop_q;
  logic              hdr_auto_q;
  logic              auto_hit, auto_cond, capture, handshake;
  logic [PAD_W-1:0]  snap_pad;

  always_comb begin
    auto_hit = 1'b0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (counters_flat[i*COUNTER_WIDTH +: COUNTER_WIDTH] >= THRESH) auto_hit = 1'b1;
    end
  end

  assign auto_cond      = auto_en && auto_hit;
  // Gated by rst_n so a reset cycle can never clear the upstream counters.
  assign capture        = (state_q == ST_IDLE) && rst_n && (snapshot_req || auto_cond);
  assign counters_clear = capture;
  assign busy           = (state_q != ST_IDLE);
  assign m_axis_tvalid  = busy;
  assign m_axis_tlast   = (state_q == ST_DATA) && (beat_q == LAST_BEAT);
  assign handshake      = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (capture) state_d = ST_HEADER;
      ST_HEADER: if (handshake) state_d = ST_DATA;
      ST_DATA:   if (handshake && m_axis_tlast) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output beat is decoded from held registers, so it stays stable through any stall.
  always_comb begin
    snap_pad               = '0;
    snap_pad[SNAP_W-1:0]   = snap_q;
    m_axis_tdata           = '0;
    if (state_q == ST_HEADER) begin
      m_axis_tdata[15:0]  = seq_q;
      m_axis_tdata[31:16] = hdr_drop_q;
      m_axis_tdata[32]    = hdr_auto_q;
    end else if (state_q == ST_DATA) begin
      for (int k = 0; k < NUM_BEATS; k++) begin
        if (beat_q == BEAT_W'(k)) m_axis_tdata = snap_pad[k*TDATA_WIDTH +: TDATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      snap_q     <= '0;
      beat_q     <= '0;
      seq_q      <= '0;
      drop_q     <= '0;
      hdr_drop_q <= '0;
      hdr_auto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        snap_q     <= counters_flat;
        hdr_drop_q <= drop_q;
        hdr_auto_q <= auto_cond;
        drop_q     <= '0;
        beat_q     <= '0;
      end else begin
        if (busy && snapshot_req && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
        if (handshake && (state_q == ST_HEADER)) seq_q <= seq_q + 16'd1;
        if (handshake && (state_q == ST_DATA)) beat_q <= beat_q + BEAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pec_snapshot_streamer.sv
// Bench for pec_snapshot_streamer: a queue-of-beats reference model checks every cycle,
// plus a capture-condition table and directed multi-cycle sequences.
module tb_pec_snapshot_streamer;

  localparam int NC     = 115;
  localparam int CW     = 7;
  localparam int TW     = 64;
  localparam int THR    = 120;
  localparam int SNAP_W = NC * CW;
  localparam int NB     = (SNAP_W + TW - 1) / TW;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [SNAP_W-1:0] counters_flat = '0;
  logic              snapshot_req = 1'b0;
  logic              auto_en = 1'b0;
  logic              counters_clear;
  logic              busy;
  logic [TW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic              m_axis_tlast;

  pec_snapshot_streamer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .counters_flat  (counters_flat),
    .snapshot_req   (snapshot_req),
    .auto_en        (auto_en),
    .counters_clear (counters_clear),
    .busy           (busy),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit any_hit(input logic [SNAP_W-1:0] c);
    for (int i = 0; i < NC; i++) begin
      if (int'(c[i*CW +: CW]) >= THR) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Reference model: a packet is a queue of expected beats; the head is what must be on the bus.
  logic [63:0] exp_q[$];
  logic [15:0] m_seq = '0;
  logic [15:0] m_drop = '0;

  initial begin
    logic [NB*TW-1:0] pad;
    bit               hit, exp_clear, auto_flag;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        hit       = any_hit(counters_flat);
        auto_flag = auto_en && hit;
        exp_clear = rst_n && (exp_q.size() == 0) && (snapshot_req || auto_flag);
        check("counters_clear", 64'(counters_clear), 64'(exp_clear));
        check("busy", 64'(busy), 64'(exp_q.size() != 0));
        check("tvalid", 64'(m_axis_tvalid), 64'(exp_q.size() != 0));
        check("tlast", 64'(m_axis_tlast), 64'(exp_q.size() == 1));
        if (exp_q.size() != 0) check("tdata", m_axis_tdata, exp_q[0]);
        // Advance the model to the state after the coming edge.
        if (!rst_n) begin
          exp_q.delete();
          m_seq  = '0;
          m_drop = '0;
        end else if (exp_clear) begin
          exp_q.push_back({31'b0, auto_flag, m_drop, m_seq});
          m_drop = '0;
          pad = '0;
          pad[SNAP_W-1:0] = counters_flat;
          for (int k = 0; k < NB; k++) exp_q.push_back(pad[k*TW +: TW]);
        end else if (exp_q.size() != 0) begin
          if (snapshot_req && (m_drop != 16'hFFFF)) m_drop = m_drop + 16'd1;
          if (m_axis_tready) begin
            if (exp_q.size() == NB + 1) m_seq = m_seq + 16'd1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  logic [63:0] pkt_d[NB+1];
  logic        pkt_l[NB+1];

  task automatic get_beat(input int idx);
    int n = 0;
    forever begin
      @(negedge clk);
      if (m_axis_tvalid && m_axis_tready) break;
      n++;
      if (n > 200) begin
        check("beat_timeout", 64'(n), 64'(0));
        pkt_d[idx] = '0;
        pkt_l[idx] = 1'b0;
        return;
      end
    end
    pkt_d[idx] = m_axis_tdata;
    pkt_l[idx] = m_axis_tlast;
  endtask

  task automatic get_packet();
    for (int i = 0; i <= NB; i++) get_beat(i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, n);
        $fatal(1, "bench stuck");
      end
    end
  endtask

  task automatic send_req();
    @(posedge clk); #1;
    snapshot_req = 1'b1;
    @(posedge clk); #1;
    snapshot_req = 1'b0;
  endtask

  task automatic set_field(input int idx, input int val);
    counters_flat[idx*CW +: CW] = CW'(val);
  endtask

  typedef struct {
    int idx;
    int val;
    bit auto_en;
    bit req;
    bit exp_clear;
    bit exp_auto;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{3,   5,   1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{0,   120, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{0,   119, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{114, 127, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{114, 127, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{60,  120, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{60,  119, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{57,  127, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", m_axis_tdata, 64'(0));
    check("rst_clear", 64'(counters_clear), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic packet: field 3 = 5, field 114 = 0x7F
    set_field(3, 5);
    set_field(114, 127);
    send_req();
    get_packet();
    check("tp1_header", pkt_d[0], 64'h0);
    check("tp1_beat0_f3", 64'(pkt_d[1][27:21]), 64'(5));
    check("tp1_beat12_f114", 64'(pkt_d[NB][36:30]), 64'h7F);
    check("tp1_beat12_pad", 64'(pkt_d[NB][63:37]), 64'h0);
    for (int i = 0; i < NB; i++) check("tp1_tlast_early", 64'(pkt_l[i]), 64'(0));
    check("tp1_tlast_last", 64'(pkt_l[NB]), 64'(1));

    wait_idle();
    send_req();
    get_packet();
    check("seq_second", 64'(pkt_d[0][15:0]), 64'(1));

    // Capture-condition table
    for (int t = 0; t < 8; t++) begin
      wait_idle();
      @(posedge clk); #1;
      counters_flat = '0;
      set_field(tbl[t].idx, tbl[t].val);
      auto_en      = tbl[t].auto_en;
      snapshot_req = tbl[t].req;
      @(negedge clk);
      check($sformatf("tbl%0d_clear", t), 64'(counters_clear), 64'(tbl[t].exp_clear));
      @(posedge clk); #1;
      snapshot_req  = 1'b0;
      auto_en       = 1'b0;
      counters_flat = '0;
      if (tbl[t].exp_clear) begin
        get_packet();
        check($sformatf("tbl%0d_auto", t), 64'(pkt_d[0][32]), 64'(tbl[t].exp_auto));
      end else begin
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("tbl%0d_idle", t), 64'(busy), 64'(0));
      end
    end

    // Three drops during DATA with 50% backpressure
    wait_idle();
    @(posedge clk); #1;
    counters_flat = '0;
    set_field(10, 77);
    snapshot_req = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      snapshot_req  = (c == 6 || c == 10 || c == 14);
      m_axis_tready = c[0];
      if (!busy && c > 2) break;
    end
    snapshot_req  = 1'b0;
    m_axis_tready = 1'b1;
    wait_idle();
    send_req();
    get_packet();
    check("drops_three", 64'(pkt_d[0][31:16]), 64'(3));
    wait_idle();
    send_req();
    get_packet();
    check("drops_cleared", 64'(pkt_d[0][31:16]), 64'(0));

    // Header stall for 20 cycles, then a request on the final handshake
    wait_idle();
    @(posedge clk); #1;
    snapshot_req  = 1'b1;
    m_axis_tready = 1'b0;
    @(posedge clk); #1;
    snapshot_req  = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    repeat (NB) @(posedge clk);
    #1;
    snapshot_req = 1'b1;
    @(negedge clk);
    check("final_beat_tlast", 64'(m_axis_tlast), 64'(1));
    @(posedge clk); #1;
    snapshot_req = 1'b0;
    wait_idle();
    send_req();
    get_packet();
    check("drop_on_final", 64'(pkt_d[0][31:16]), 64'(1));

    // Reset while beat 5 is on the bus
    wait_idle();
    send_req();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_mid_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_mid_tdata", m_axis_tdata, 64'(0));
    send_req();
    get_packet();
    check("rst_mid_seq", 64'(pkt_d[0][15:0]), 64'(0));

    // Randomized traffic against the model
    wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NC; i++) set_field(i, int'($urandom_range(0, THR - 1)));
      if ($urandom_range(0, 9) == 0) set_field(int'($urandom_range(0, NC - 1)),
                                               int'($urandom_range(THR, 127)));
      auto_en       = ($urandom_range(0, 3) == 0);
      snapshot_req  = ($urandom_range(0, 7) == 0);
      m_axis_tready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
    end
    @(posedge clk); #1;
    snapshot_req = 1'b0;
    auto_en      = 1'b0;
    rst_n        = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors", n_vec);
    $fatal(1, "timeout");
  end

endmodule
